// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default rates, majority helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Default system clock and line rate, shared with the transmit-side baud generator
    localparam int unsigned CLK_HZ_DEF = 12_000_000;
    localparam int unsigned BAUD_DEF   = 9600;

    // Default oversample factor (must be even and at least 8)
    localparam int unsigned OVS_DEF    = 16;

    // Receiver FSM states; codes 5..7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // Two-out-of-three vote used on the mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, synchronous clear.
// Latency: first tick DIV cycles after clr drops.
// Backpressure: none; free-running while clr is low.
module uart_os_tick #(
    parameter int unsigned DIV = 78
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);

    // Divider counter: held at zero while cleared so timing aligns to the release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop sync, OVS oversampling, 3-sample majority, LSB-first, stop check.
// Latency: rx_valid rises 1 cycle after the mid-stop-bit decision tick (+2 sync cycles).
// Backpressure: single holding register; an unconsumed byte is overwritten and rx_overrun pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned BAUD   = BAUD_DEF,
    parameter int unsigned OVS    = OVS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    // Clocks per oversample tick (truncated)
    localparam int unsigned DIV = CLK_HZ / (BAUD * OVS);
    localparam int unsigned OW  = $clog2(OVS);

    // Sample points around mid-bit, and the end-of-bit position
    localparam logic [OW-1:0] OS_S0   = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OS_S1   = OW'(OVS / 2);
    localparam logic [OW-1:0] OS_S2   = OW'(OVS / 2 + 1);
    localparam logic [OW-1:0] OS_LAST = OW'(OVS - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            rxs;
    logic            tick;
    logic            tick_clr;

    rx_state_e       state_q;
    logic [OW-1:0]   os_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [1:0]      smp_q;
    logic            maj_q;
    logic            maj_d;
    logic [7:0]      shreg_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            overrun_q;
    logic            busy_q;

    assign rxs = sync2_q;

    // Bit timing restarts from zero at the start edge
    assign tick_clr = (state_q == IDLE);

    uart_os_tick #(
        .DIV(DIV)
    ) u_os_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    // Vote uses the two stored samples plus the live third sample, so the
    // decision can be taken on the same tick that the third sample arrives
    assign maj_d = maj3(smp_q[0], smp_q[1], rxs);

    // Two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM with oversample counter, sampling, deserialiser and output holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            smp_q       <= '0;
            maj_q       <= 1'b0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Flag outputs are single-cycle pulses
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Consumer handshake; a load later in this block takes priority
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            // Oversample position and mid-bit sample capture
            if (tick && (state_q != IDLE)) begin
                os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OW'(1);
                if (os_cnt_q == OS_S0) smp_q[0] <= rxs;
                if (os_cnt_q == OS_S1) smp_q[1] <= rxs;
                if (os_cnt_q == OS_S2) maj_q    <= maj_d;
            end

            case (state_q)
                IDLE: begin
                    os_cnt_q  <= '0;
                    bit_cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if ((os_cnt_q == OS_S2) && maj_d) begin
                            // Line back high by mid start bit: noise, not a frame
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (os_cnt_q == OS_LAST) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end

                DATA: begin
                    if (tick && (os_cnt_q == OS_LAST)) begin
                        shreg_q   <= {maj_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    // Decide at mid stop bit so a following start edge is not missed
                    if (tick && (os_cnt_q == OS_S2)) begin
                        if (maj_d) begin
                            rx_data_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                            overrun_q  <= rx_valid_q && !rx_ready;
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end

                WAIT_HIGH: begin
                    // Break or stuck-low line: wait quietly for the line to return idle
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: behavioural line driver, expected-byte queue, decoupled monitor.
// Latency: uses a fast configuration (DIV=3, OVS=8, 24 clocks per bit).
// Backpressure: rx_ready driven directly per scenario.
module tb_uart_rx_core;

    localparam int unsigned T_CLK_HZ = 2_400_000;
    localparam int unsigned T_BAUD   = 100_000;
    localparam int unsigned T_OVS    = 8;
    localparam int DIV = T_CLK_HZ / (T_BAUD * T_OVS);
    localparam int BIT = DIV * T_OVS;
    // Negedges from the start-bit falling edge to the one just before the stop decision edge:
    // 2 sync stages + 1 detect cycle, then 8 start + 64 data + (OVS/2+2) stop ticks
    localparam int DEC_NEG = 3 + DIV * (9 * T_OVS + T_OVS / 2 + 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vld_cyc = 0;
    logic [7:0] exp_q[$];

    uart_rx_core #(
        .CLK_HZ(T_CLK_HZ),
        .BAUD  (T_BAUD),
        .OVS   (T_OVS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bit period on the line; optional one-tick low glitch at mid-bit
    task automatic drive_bit(input logic v, input bit glitch);
        for (int c = 0; c < BIT; c++) begin
            @(negedge clk);
            rx_in = (glitch && c >= BIT / 2 && c < BIT / 2 + DIV) ? 1'b0 : v;
        end
    endtask

    // 8N1 frame, LSB first; gbit selects a data bit to glitch (-1 for none)
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit);
        drive_bit(1'b0, 1'b0);
        for (int j = 0; j < 8; j++) drive_bit(b[j], j == gbit);
        drive_bit(stop_v, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: counts flag pulses, pops the scoreboard on every accepted byte
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (rx_frame_err) fe_cnt++;
                if (rx_overrun)   ov_cnt++;
                if (rx_valid)     vld_cyc++;
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected: got byte 0x%02h, expected none", rx_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("sb_byte", rx_data, exp_b);
                    end
                end
            end
        end
    end

    // Watchdog bounds the whole run
    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, expected completion");
        $fatal(1);
    end

    initial begin
        int fe0, ov0, v0;
        logic [7:0] b;

        rst = 1'b0;
        rx_in = 1'b1;
        rx_ready = 1'b0;
        #1;
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_fe", rx_frame_err, 0);
        check("rst_ov", rx_overrun, 0);
        check("rst_busy", rx_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(BIT);

        // Clean frame with consumer always ready
        rx_ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        wait_drain("a5_drain", 4 * BIT);
        idle(4);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid_cycles", vld_cyc - v0, 1);
        check("a5_fe", fe_cnt - fe0, 0);
        check("a5_ov", ov_cnt - ov0, 0);
        check("a5_busy", rx_busy, 0);

        // False start: low for three ticks only
        fe0 = fe_cnt; v0 = vld_cyc;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            rx_in = 1'b0;
        end
        check("fs_busy_mid", rx_busy, 1);
        idle(2 * BIT);
        check("fs_busy", rx_busy, 0);
        check("fs_valid", vld_cyc - v0, 0);
        check("fs_fe", fe_cnt - fe0, 0);

        // Framing error with the line held low afterwards
        fe0 = fe_cnt; v0 = vld_cyc;
        send_frame(8'h3C, 1'b0, -1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        check("fe_pulse", fe_cnt - fe0, 1);
        check("fe_wait_busy", rx_busy, 1);
        check("fe_valid", rx_valid, 0);
        idle(BIT);
        check("fe_busy_after", rx_busy, 0);
        check("fe_pulse_total", fe_cnt - fe0, 1);
        check("fe_no_valid", vld_cyc - v0, 0);

        // Back-to-back with consumer stalled: first byte is lost to overrun
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1);
        check("ov_first_valid", rx_valid, 1);
        check("ov_first_data", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, -1);
        check("ov_pulse", ov_cnt - ov0, 1);
        check("ov_data", rx_data, 8'h22);
        check("ov_valid", rx_valid, 1);
        exp_q.push_back(8'h22);
        rx_ready = 1'b1;
        wait_drain("ov_drain", 8);
        @(negedge clk);
        rx_ready = 1'b0;
        check("ov_valid_cleared", rx_valid, 0);

        // Consumer accepts in the same cycle the next byte completes
        ov0 = ov_cnt;
        send_frame(8'h33, 1'b1, -1);
        exp_q.push_back(8'h33);
        fork
            send_frame(8'h44, 1'b1, -1);
            begin
                repeat (DEC_NEG) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        check("sim_ov", ov_cnt - ov0, 0);
        check("sim_valid", rx_valid, 1);
        check("sim_data", rx_data, 8'h44);
        check("sim_popped", exp_q.size(), 0);
        exp_q.push_back(8'h44);
        rx_ready = 1'b1;
        wait_drain("sim_drain", 8);

        // Single-tick glitch inside a '1' data bit
        fe0 = fe_cnt;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 3);
        wait_drain("gl_drain", 4 * BIT);
        check("gl_data", rx_data, 8'hFF);
        check("gl_fe", fe_cnt - fe0, 0);

        // Reset in the middle of a frame, then a clean frame
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cyc;
        b = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int j = 0; j < 4; j++) drive_bit(b[j], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rx_in = 1'b1;
        #1;
        check("mr_data", rx_data, 0);
        check("mr_valid", rx_valid, 0);
        check("mr_busy", rx_busy, 0);
        check("mr_flags", {rx_frame_err, rx_overrun}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(3 * BIT);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        wait_drain("mr_drain", 4 * BIT);
        check("mr_data_after", rx_data, 8'h81);
        check("mr_fe", fe_cnt - fe0, 0);
        check("mr_ov", ov_cnt - ov0, 0);
        check("mr_valid_cycles", vld_cyc - v0, 1);

        // Stream of 256 random bytes with random short idle gaps
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cyc;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, -1);
            idle($urandom_range(0, 3));
        end
        wait_drain("st_drain", 4 * BIT);
        check("st_fe", fe_cnt - fe0, 0);
        check("st_ov", ov_cnt - ov0, 0);
        check("st_valid_cycles", vld_cyc - v0, 256);
        idle(BIT);
        check("st_busy", rx_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
